// File: rtl/soc_onchip_mem_pkg.sv
// rtl/soc_onchip_mem_pkg.sv - shared types, constants and helpers for the on-chip RAM slave
//
// Purpose : FSM state type, default geometry constants and the per-byte parity
//           helper used by the parity build (macro SOC_ONCHIP_MEM_PARITY_EN).
// Ports   : none (package).
package soc_onchip_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 64;
  localparam int BE_W           = DEFAULT_DATA_W / 8;

  // Even parity: the stored bit makes the byte plus parity carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/soc_system_onchip_mem_pipelined_if.sv
// rtl/soc_system_onchip_mem_pipelined_if.sv - Avalon-MM s1 bundle for the on-chip RAM slave
//
// Purpose : groups the s1 request/response signals.
// Ports   : address, byteenable, chipselect, read, write, writedata (master -> slave);
//           readdata, readdatavalid, waitrequest (slave -> master).
interface soc_system_onchip_mem_pipelined_if
  import soc_onchip_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 9
) ();

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/soc_onchip_mem_ram.sv
// rtl/soc_onchip_mem_ram.sv - inferred single-port byte-enabled RAM, one-cycle read
//
// Purpose : storage array; when W exceeds 8*NB the extra top bits are one
//           parity bit per byte lane, written with that lane's enable.
// Ports   : clk, i_en (clock enable, holds everything), i_we, i_re, i_be,
//           i_addr, i_wdata, o_q (read word, updated only on enabled reads).
module soc_onchip_mem_ram
  import soc_onchip_mem_pkg::*;
#(
  parameter int W      = DEFAULT_DATA_W,
  parameter int NB     = BE_W,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [NB-1:0]     i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [W-1:0]      i_wdata,
  output logic [W-1:0]      o_q
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] w_mask;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign w_mask[8*b +: 8] = {8{i_be[b]}};
  end

  if (W > 8 * NB) begin : g_par
    for (genvar b = 0; b < NB; b++) begin : g_par_lane
      assign w_mask[8*NB + b] = i_be[b];
    end
  end

  // Callers only raise i_we/i_re for in-range addresses.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
      end
      if (i_re) begin
        o_q <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/soc_system_onchip_mem_pipelined.sv
// rtl/soc_system_onchip_mem_pipelined.sv - pipelined on-chip RAM Avalon-MM slave with zero-fill
//
// Purpose : single-port RAM behind an Avalon-MM slave; post-reset zero-fill
//           FSM, read latency 1+OUTREG enabled cycles, global clock enable.
//           Optional per-byte even parity under macro SOC_ONCHIP_MEM_PARITY_EN.
// Ports   : clk, reset (async, active high), s1 (slave bundle), clken,
//           reset_req, freeze, init_done, parity_err.
module soc_system_onchip_mem_pipelined
  import soc_onchip_mem_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 9,
  parameter int OUTREG    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic clk,
  input  logic reset,
  soc_system_onchip_mem_pipelined_if.slave s1,
  input  logic clken,
  input  logic reset_req,
  input  logic freeze,
  output logic init_done,
  output logic parity_err
);

  localparam int NB = DATA_W / 8;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
  localparam int RAM_W = DATA_W + NB;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_addr;
  logic              r_init_done;

  logic              w_run;
  logic              w_waitreq;
  logic              w_req;
  logic              w_wr;
  logic              w_rd;
  logic              w_in_range;

  logic              w_ram_we;
  logic              w_ram_re;
  logic [NB-1:0]     w_ram_be;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [RAM_W-1:0]  w_ram_wdata;
  logic [RAM_W-1:0]  w_wdata_full;
  logic [RAM_W-1:0]  w_ram_q;

  logic              r_rd_v1;
  logic              r_oor1;
  logic [DATA_W-1:0] w_d1;

  assign w_run      = (r_state == RUN);
  // clken=0 must look like a stall to the interconnect, not a dropped request.
  assign w_waitreq  = ~w_run | ~clken | reset_req | freeze;
  assign w_req      = s1.chipselect & (s1.read | s1.write) & ~w_waitreq;
  assign w_wr       = w_req & s1.write;
  // A combined read+write is treated as a write only.
  assign w_rd       = w_req & s1.read & ~s1.write;
  assign w_in_range = ({1'b0, s1.address} < DEPTH_V);

  assign s1.waitrequest = w_waitreq;
  assign init_done      = r_init_done;

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_be    = '0;
    w_ram_addr  = s1.address;
    w_ram_wdata = '0;
    if (!w_run) begin
      w_ram_we   = 1'b1;
      w_ram_be   = '1;
      w_ram_addr = r_init_addr;
    end else begin
      w_ram_we    = w_wr & w_in_range;
      w_ram_re    = w_rd & w_in_range;
      w_ram_be    = s1.byteenable;
      w_ram_wdata = w_wdata_full;
    end
  end

  soc_onchip_mem_ram #(
    .W      (RAM_W),
    .NB     (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (clken),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  // Zero-fill FSM: one word per enabled cycle, then RUN with init_done set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= (INIT_ZERO != 0) ? INIT : RUN;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else if (clken) begin
      case (r_state)
        INIT: begin
          if (r_init_addr == ADDR_W'(DEPTH - 1)) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end else begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
          end
        end
        RUN:     r_init_done <= 1'b1;
        default: r_state     <= RUN;
      endcase
    end
  end

  // Stage 1 tracks the word now sitting on the RAM output; out-of-range
  // reads still produce a beat but with zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_v1 <= 1'b0;
      r_oor1  <= 1'b0;
    end else if (clken) begin
      r_rd_v1 <= w_rd;
      r_oor1  <= ~w_in_range;
    end
  end

  // Gated by valid so readdata stays 0 outside beats (and from reset).
  assign w_d1 = (r_rd_v1 & ~r_oor1) ? w_ram_q[DATA_W-1:0] : '0;

  if (OUTREG != 0) begin : g_outreg
    logic              r_v2;
    logic [DATA_W-1:0] r_d2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else if (clken) begin
        r_v2 <= r_rd_v1;
        r_d2 <= w_d1;
      end
    end
    assign s1.readdatavalid = r_v2;
    assign s1.readdata      = r_d2;
  end else begin : g_direct
    assign s1.readdatavalid = r_rd_v1;
    assign s1.readdata      = w_d1;
  end

`ifdef SOC_ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] w_wpar;
  logic [NB-1:0] w_pmis;
  logic          r_perr;

  always_comb begin
    w_wpar = '0;
    w_pmis = '0;
    for (int b = 0; b < NB; b++) begin
      w_wpar[b] = byte_parity(s1.writedata[8*b +: 8]);
      w_pmis[b] = byte_parity(w_ram_q[8*b +: 8]) ^ w_ram_q[DATA_W + b];
    end
  end

  assign w_wdata_full = {w_wpar, s1.writedata};

  // Checked on the word at the RAM output; data itself is passed through as stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (clken && r_rd_v1 && !r_oor1 && (|w_pmis)) begin
      r_perr <= 1'b1;
    end
  end

  assign parity_err = r_perr;
`else
  assign w_wdata_full = s1.writedata;
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_onchip_mem_pipelined.sv
// tb/tb_soc_system_onchip_mem_pipelined.sv - scoreboard bench for the on-chip RAM slave
module tb_soc_system_onchip_mem_pipelined;
  import soc_onchip_mem_pkg::*;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  logic freeze = 1'b0;
  logic init_done0, init_done1, perr0, perr1;

  int   errs = 0;
  int   checks = 0;
  int   ecnt = 0;
  bit   done_model = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] mdl [2][512];
  int   dep [2] = '{512, 300};
  int   lat [2] = '{2, 1};

  always #5 clk = ~clk;

  soc_system_onchip_mem_pipelined_if #(.DATA_W(64), .ADDR_W(9)) bus0 ();
  soc_system_onchip_mem_pipelined_if #(.DATA_W(64), .ADDR_W(9)) bus1 ();

  soc_system_onchip_mem_pipelined #(.DATA_W(64), .DEPTH(512), .ADDR_W(9), .OUTREG(1), .INIT_ZERO(1)) dut0 (
    .clk(clk), .reset(reset), .s1(bus0), .clken(clken), .reset_req(reset_req),
    .freeze(freeze), .init_done(init_done0), .parity_err(perr0));

  soc_system_onchip_mem_pipelined #(.DATA_W(64), .DEPTH(300), .ADDR_W(9), .OUTREG(0), .INIT_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .s1(bus1), .clken(clken), .reset_req(reset_req),
    .freeze(freeze), .init_done(init_done1), .parity_err(perr1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic rd, input logic wr, input logic [8:0] a,
                       input logic [BE_W-1:0] be, input logic [63:0] wd);
    bus0.chipselect = cs; bus0.read = rd; bus0.write = wr; bus0.address = a;
    bus0.byteenable = be; bus0.writedata = wd;
    bus1.chipselect = cs; bus1.read = rd; bus1.write = wr; bus1.address = a;
    bus1.byteenable = be; bus1.writedata = wd;
  endtask

  // One bus cycle; the reference model decides acceptance from the rules alone.
  task automatic cyc(input logic cs, input logic rd, input logic wr, input int a,
                     input logic [7:0] be, input logic [63:0] wd,
                     input logic ck = 1'b1, input logic rr = 1'b0, input logic fz = 1'b0);
    bit   ok;
    exp_t e;
    @(negedge clk);
    drive(cs, rd, wr, 9'(a), be, wd);
    clken = ck; reset_req = rr; freeze = fz;
    #1;
    ok = done_model && ck && !rr && !fz;
    chk("waitrequest0", 64'(bus0.waitrequest), 64'(!ok));
    chk("waitrequest1", 64'(bus1.waitrequest), 64'(!ok));
    if (ok && cs && (rd || wr)) begin
      for (int k = 0; k < 2; k++) begin
        if (wr) begin
          if (a < dep[k])
            for (int b = 0; b < 8; b++)
              if (be[b]) mdl[k][a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          e.due  = ecnt + lat[k];
          e.data = (a < dep[k]) ? mdl[k][a] : 64'h0;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 8'h00, 64'h0);
  endtask

  task automatic check_beat(input int k, input logic v, input logic [63:0] d);
    exp_t e;
    bit   have;
    if (!v) return;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!have) begin
      checks++;
      errs++;
      $display("FAIL unexpected_beat%0d: got data %h at cycle %0d expected no beat", k, d, ecnt);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("beat_cycle%0d", k), 64'(ecnt), 64'(e.due));
    chk($sformatf("readdata%0d", k), d, e.data);
  endtask

  // Monitor: a beat is new only after an edge where clken was high.
  always @(posedge clk) begin
    logic en;
    en = clken;
    #1;
    if (!reset && en) begin
      ecnt++;
      check_beat(0, bus0.readdatavalid, bus0.readdata);
      check_beat(1, bus1.readdatavalid, bus1.readdata);
    end
  end

  task automatic do_reset();
    int n0, n1, viol;
    @(negedge clk);
    reset = 1'b1; done_model = 0;
    q0.delete(); q1.delete();
    drive(1'b0, 1'b0, 1'b0, 9'd0, 8'h00, 64'h0);
    clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
    #1;
    chk("rst_waitreq0", 64'(bus0.waitrequest), 64'd1);
    chk("rst_waitreq1", 64'(bus1.waitrequest), 64'd1);
    chk("rst_rdv0", 64'(bus0.readdatavalid), 64'd0);
    chk("rst_rdv1", 64'(bus1.readdatavalid), 64'd0);
    chk("rst_rdata0", bus0.readdata, 64'd0);
    chk("rst_init_done0", 64'(init_done0), 64'd0);
    chk("rst_init_done1", 64'(init_done1), 64'd0);
    chk("rst_parity0", 64'(perr0), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = -1; n1 = -1; viol = 0;
    for (int c = 1; c <= 600 && n0 < 0; c++) begin
      @(posedge clk);
      #1;
      if (init_done0) n0 = c;
      else if (!bus0.waitrequest) viol++;
      if (n1 < 0) begin
        if (init_done1) n1 = c;
        else if (!bus1.waitrequest) viol++;
      end
    end
    chk("init_cycles0", 64'(n0), 64'd512);
    chk("init_cycles1", 64'(n1), 64'd300);
    chk("init_waitreq_low", 64'(viol), 64'd0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 512; i++) mdl[k][i] = 64'h0;
    done_model = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 9'd0, 8'h00, 64'h0);
    do_reset();

    cyc(1, 1, 0, 17, 8'h00, 64'h0);
    cyc(1, 0, 1, 5, 8'hFF, 64'h1122334455667788);
    cyc(1, 0, 1, 5, 8'h0F, 64'hFFFFFFFFAAAABBBB);
    cyc(1, 1, 0, 5, 8'h00, 64'h0);
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, i, 8'hFF, {32'hA5A5_0000, 32'(i * 16'h1111)});
    for (int i = 1; i <= 3; i++) cyc(1, 1, 0, i, 8'h00, 64'h0);
    idle(4);
    cyc(1, 1, 0, 1, 8'h00, 64'h0);
    cyc(1, 1, 0, 2, 8'h00, 64'h0);
    repeat (3) cyc(1, 1, 0, 3, 8'h00, 64'h0, 1'b0);
    idle(4);
    cyc(1, 0, 1, 400, 8'hFF, 64'hDEAD_BEEF_0400_0400);
    cyc(1, 1, 0, 400, 8'h00, 64'h0);
    cyc(1, 1, 0, 100, 8'h00, 64'h0);
    cyc(1, 1, 0, 144, 8'h00, 64'h0);
    cyc(1, 0, 1, 7, 8'hFF, 64'h0707_0707_7070_7070);
    cyc(1, 1, 0, 7, 8'h00, 64'h0);
    cyc(1, 1, 1, 9, 8'hFF, 64'h0909_0909_9090_9090);
    cyc(1, 1, 0, 9, 8'h00, 64'h0);
    cyc(1, 1, 0, 5, 8'h00, 64'h0, 1'b1, 1'b1, 1'b0);
    cyc(1, 1, 0, 5, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    idle(4);

    for (int n = 0; n < 3000; n++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(280, 420)) : int'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), a, 8'($urandom),
          {$urandom, $urandom}, 1'($urandom_range(0, 6) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0));
    end
    idle(6);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("parity_clean0", 64'(perr0), 64'd0);
    chk("parity_clean1", 64'(perr1), 64'd0);

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, i + 1, 8'h00, 64'h0);
    do_reset();
    cyc(1, 1, 0, 2, 8'h00, 64'h0);
    idle(4);

    @(negedge clk); reset = 1'b1; done_model = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    do_reset();
    cyc(1, 1, 0, 5, 8'h00, 64'h0);
    idle(4);

`ifdef SOC_ONCHIP_MEM_PARITY_EN
    dut0.u_ram.r_mem[8][64] = ~dut0.u_ram.r_mem[8][64];
    cyc(1, 1, 0, 8, 8'h00, 64'h0);
    idle(4);
    chk("parity_set", 64'(perr0), 64'd1);
    idle(10);
    chk("parity_sticky", 64'(perr0), 64'd1);
    do_reset();
`endif
    chk("drain_end0", 64'(q0.size()), 64'd0);
    chk("drain_end1", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
